// File: rtl/front_spi_arbiter.sv
// rtl/front_spi_arbiter.sv - round-robin arbiter/sequencer sharing the front-panel SPI master between two requesters
// Each requester has a one-deep request latch; a watchdog forces completion if the master never reports done.
module front_spi_arbiter #(
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 8000,
  parameter int GAP     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_start,
  input  logic [DATA_W-1:0] i_req0_mosi,
  input  logic [1:0]        i_req0_dev,
  output logic              o_req0_busy,
  output logic              o_req0_done,
  output logic [DATA_W-1:0] o_req0_miso,
  input  logic              i_req1_start,
  input  logic [DATA_W-1:0] i_req1_mosi,
  input  logic [1:0]        i_req1_dev,
  output logic              o_req1_busy,
  output logic              o_req1_done,
  output logic [DATA_W-1:0] o_req1_miso,
  output logic              o_spi_start,
  output logic [DATA_W-1:0] o_spi_mosi,
  output logic [1:0]        o_spi_dev,
  input  logic              i_spi_done,
  input  logic [DATA_W-1:0] i_spi_miso,
  output logic [1:0]        o_grant,
  output logic              o_timeout_err,
  input  logic              i_err_clear
);

  localparam int CNT_W = $clog2((TIMEOUT > GAP) ? TIMEOUT : GAP) + 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_XFER,
    S_GAP
  } state_t;

  state_t            r_state;
  logic              r_pend0;
  logic              r_pend1;
  logic [DATA_W-1:0] r_mosi0;
  logic [DATA_W-1:0] r_mosi1;
  logic [1:0]        r_dev0;
  logic [1:0]        r_dev1;
  logic              r_owner;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_active;
  logic              w_accept0;
  logic              w_accept1;
  logic              w_pick1;
  logic [DATA_W-1:0] w_result;

  // Ownership ends with the done pulse, so a requester may re-arm during GAP.
  assign w_active    = (r_state == S_LAUNCH) || (r_state == S_XFER);
  assign o_req0_busy = r_pend0 | (w_active & ~r_owner);
  assign o_req1_busy = r_pend1 | (w_active &  r_owner);

  assign w_accept0 = i_req0_start & ~o_req0_busy;
  assign w_accept1 = i_req1_start & ~o_req1_busy;
  // r_last holds the index granted last; on a tie the other requester wins.
  assign w_pick1   = r_pend1 & (~r_pend0 | ~r_last);
  assign w_result  = i_spi_done ? i_spi_miso : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_pend0       <= 1'b0;
      r_pend1       <= 1'b0;
      r_mosi0       <= '0;
      r_mosi1       <= '0;
      r_dev0        <= '0;
      r_dev1        <= '0;
      r_owner       <= 1'b0;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      o_req0_done   <= 1'b0;
      o_req0_miso   <= '0;
      o_req1_done   <= 1'b0;
      o_req1_miso   <= '0;
      o_spi_start   <= 1'b0;
      o_spi_mosi    <= '0;
      o_spi_dev     <= '0;
      o_grant       <= 2'b00;
      o_timeout_err <= 1'b0;
    end else begin
      o_spi_start <= 1'b0;
      o_req0_done <= 1'b0;
      o_req1_done <= 1'b0;
      if (i_err_clear) begin
        o_timeout_err <= 1'b0;
      end
      if (w_accept0) begin
        r_pend0 <= 1'b1;
        r_mosi0 <= i_req0_mosi;
        r_dev0  <= i_req0_dev;
      end
      if (w_accept1) begin
        r_pend1 <= 1'b1;
        r_mosi1 <= i_req1_mosi;
        r_dev1  <= i_req1_dev;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend0 || r_pend1) begin
            r_owner     <= w_pick1;
            r_last      <= w_pick1;
            o_spi_start <= 1'b1;
            r_state     <= S_LAUNCH;
            if (w_pick1) begin
              o_spi_mosi <= r_mosi1;
              o_spi_dev  <= r_dev1;
              r_pend1    <= 1'b0;
              o_grant    <= 2'b10;
            end else begin
              o_spi_mosi <= r_mosi0;
              o_spi_dev  <= r_dev0;
              r_pend0    <= 1'b0;
              o_grant    <= 2'b01;
            end
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_XFER;
        end
        S_XFER: begin
          // A real completion on the last watchdog cycle still wins.
          if (i_spi_done || (r_cnt == TO_LAST)) begin
            if (r_owner) begin
              o_req1_miso <= w_result;
              o_req1_done <= 1'b1;
            end else begin
              o_req0_miso <= w_result;
              o_req0_done <= 1'b1;
            end
            if (!i_spi_done) begin
              o_timeout_err <= 1'b1;
            end
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            o_grant <= 2'b00;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_front_spi_arbiter.sv
// tb/tb_front_spi_arbiter.sv - directed and randomized self-checking bench for front_spi_arbiter
// Expected transfers come from a transaction-level model of request latching and round-robin order.
module tb_front_spi_arbiter;
  localparam int DW = 24;
  localparam int TO = 300;
  localparam int GP = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_req0_start = 1'b0, i_req1_start = 1'b0;
  logic [DW-1:0] i_req0_mosi = '0, i_req1_mosi = '0;
  logic [1:0]    i_req0_dev = '0, i_req1_dev = '0;
  logic          o_req0_busy, o_req0_done, o_req1_busy, o_req1_done;
  logic [DW-1:0] o_req0_miso, o_req1_miso;
  logic          o_spi_start;
  logic [DW-1:0] o_spi_mosi;
  logic [1:0]    o_spi_dev;
  logic          i_spi_done = 1'b0;
  logic [DW-1:0] i_spi_miso = '0;
  logic [1:0]    o_grant;
  logic          o_timeout_err;
  logic          i_err_clear = 1'b0;

  front_spi_arbiter #(.DATA_W(DW), .TIMEOUT(TO), .GAP(GP)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_start(i_req0_start), .i_req0_mosi(i_req0_mosi), .i_req0_dev(i_req0_dev),
    .o_req0_busy(o_req0_busy), .o_req0_done(o_req0_done), .o_req0_miso(o_req0_miso),
    .i_req1_start(i_req1_start), .i_req1_mosi(i_req1_mosi), .i_req1_dev(i_req1_dev),
    .o_req1_busy(o_req1_busy), .o_req1_done(o_req1_done), .o_req1_miso(o_req1_miso),
    .o_spi_start(o_spi_start), .o_spi_mosi(o_spi_mosi), .o_spi_dev(o_spi_dev),
    .i_spi_done(i_spi_done), .i_spi_miso(i_spi_miso),
    .o_grant(o_grant), .o_timeout_err(o_timeout_err), .i_err_clear(i_err_clear)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dc0 = 0, dc1 = 0, launch_cnt = 0;
  int t_done = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_req0_done === 1'b1) dc0 <= dc0 + 1;
    if (o_req1_done === 1'b1) dc1 <= dc1 + 1;
    if (o_spi_start === 1'b1) launch_cnt <= launch_cnt + 1;
  end

  // Reference model: one-deep request latch per requester and the last-granted index.
  bit            m_pend [2];
  logic [DW-1:0] m_mosi [2];
  logic [1:0]    m_dev  [2];
  logic [DW-1:0] m_miso [2];
  int            m_dc   [2];
  int            m_last;
  int            m_launch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_start(input int w, input logic [DW-1:0] d, input logic [1:0] v);
    if (w == 0) begin
      i_req0_start = 1'b1; i_req0_mosi = d; i_req0_dev = v;
    end else begin
      i_req1_start = 1'b1; i_req1_mosi = d; i_req1_dev = v;
    end
  endtask

  task automatic clear_starts();
    i_req0_start = 1'b0;
    i_req1_start = 1'b0;
  endtask

  task automatic model_request(input int w, input logic [DW-1:0] d, input logic [1:0] v);
    drive_start(w, d, v);
    m_pend[w] = 1'b1;
    m_mosi[w] = d;
    m_dev[w]  = v;
  endtask

  function automatic int pick();
    if (m_pend[0] && m_pend[1]) return 1 - m_last;
    return m_pend[1] ? 1 : 0;
  endfunction

  task automatic chk_all_zero();
    chk("rst_spi_start", o_spi_start, 0);
    chk("rst_spi_mosi", o_spi_mosi, 0);
    chk("rst_spi_dev", o_spi_dev, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_busy0", o_req0_busy, 0);
    chk("rst_busy1", o_req1_busy, 0);
    chk("rst_done0", o_req0_done, 0);
    chk("rst_done1", o_req1_done, 0);
    chk("rst_miso0", o_req0_miso, 0);
    chk("rst_miso1", o_req1_miso, 0);
    chk("rst_err", o_timeout_err, 0);
  endtask

  task automatic wait_launch(input int exp_cyc);
    int n = 0;
    while (o_spi_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("launch_seen", o_spi_start, 1);
    chk("launch_cycle", cyc, exp_cyc);
    m_launch++;
  endtask

  task automatic serve(input int w, input int exp_cyc, input logic [DW-1:0] miso, input bit junk);
    int dly;
    wait_launch(exp_cyc);
    chk("spi_mosi", o_spi_mosi, m_mosi[w]);
    chk("spi_dev", o_spi_dev, m_dev[w]);
    chk("grant", o_grant, (w == 0) ? 2'b01 : 2'b10);
    chk("busy_owner", (w == 0) ? o_req0_busy : o_req1_busy, 1);
    tick();
    if (junk) begin
      drive_start(w, 24'h222222, 2'd3);
      tick();
      clear_starts();
    end
    dly = $urandom_range(0, 5);
    for (int i = 0; i < dly; i++) tick();
    i_spi_done = 1'b1;
    i_spi_miso = miso;
    t_done = cyc;
    tick();
    i_spi_done = 1'b0;
    i_spi_miso = DW'($urandom);
    m_miso[w] = miso;
    m_dc[w]++;
    chk("done_pulse", (w == 0) ? o_req0_done : o_req1_done, 1);
    chk("other_done", (w == 0) ? o_req1_done : o_req0_done, 0);
    chk("miso_out", (w == 0) ? o_req0_miso : o_req1_miso, miso);
    chk("busy_fall", (w == 0) ? o_req0_busy : o_req1_busy, 0);
  endtask

  task automatic settle();
    for (int i = 0; i < GP + 3; i++) tick();
    chk("idle_grant", o_grant, 0);
    chk("idle_busy0", o_req0_busy, 0);
    chk("idle_busy1", o_req1_busy, 0);
    chk("done_count0", dc0, m_dc[0]);
    chk("done_count1", dc1, m_dc[1]);
    chk("launch_count", launch_cnt, m_launch);
    chk("hold_miso0", o_req0_miso, m_miso[0]);
    chk("hold_miso1", o_req1_miso, m_miso[1]);
  endtask

  task automatic run_batch(input int mask,
                           input logic [DW-1:0] mo0, input logic [1:0] dv0, input logic [DW-1:0] mi0,
                           input logic [DW-1:0] mo1, input logic [1:0] dv1, input logic [DW-1:0] mi1,
                           input bit junk);
    int s, w, exp;
    if (mask[0]) model_request(0, mo0, dv0);
    if (mask[1]) model_request(1, mo1, dv1);
    s = cyc;
    tick();
    clear_starts();
    exp = s + 2;
    while (m_pend[0] || m_pend[1]) begin
      w = pick();
      m_pend[w] = 1'b0;
      m_last = w;
      serve(w, exp, (w == 0) ? mi0 : mi1, junk);
      exp = t_done + GP + 2;
    end
    settle();
  endtask

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    m_miso[0] = '0; m_miso[1] = '0;
    m_last = 1;
  endtask

  initial begin
    int s, l;
    model_reset();
    m_dc[0] = 0; m_dc[1] = 0;
    m_launch = 0;

    repeat (3) tick();
    chk_all_zero();
    i_rst = 1'b1;
    tick();

    // Tie straight after reset: requester 0 first.
    run_batch(3, 24'h123456, 2'd1, 24'h654321, 24'hABCDEF, 2'd2, 24'h00FEED, 1'b0);
    run_batch(1, 24'hF85040, 2'd0, 24'h0000A5, 24'h0, 2'd0, 24'h0, 1'b0);
    run_batch(3, 24'h0F0F0F, 2'd2, 24'h5A5A5A, 24'h303030, 2'd3, 24'hC3C3C3, 1'b0);
    // Second start while busy must be dropped.
    run_batch(2, 24'h0, 2'd0, 24'h0, 24'h111111, 2'd1, 24'h777777, 1'b1);

    // Re-arm in the done cycle.
    model_request(0, 24'h0ABCDE, 2'd1);
    s = cyc;
    tick();
    clear_starts();
    m_pend[0] = 0; m_last = 0;
    serve(0, s + 2, 24'h135790, 1'b0);
    model_request(0, 24'h0FEDCB, 2'd2);
    tick();
    clear_starts();
    m_pend[0] = 0;
    serve(0, t_done + GP + 2, 24'h246802, 1'b0);
    settle();

    // Watchdog with a simultaneous clear: set wins.
    model_request(1, 24'h0C0FFE, 2'd3);
    s = cyc;
    tick();
    clear_starts();
    m_pend[1] = 0; m_last = 1;
    wait_launch(s + 2);
    l = cyc;
    while (cyc < l + TO) tick();
    chk("to_no_early_done", o_req1_done, 0);
    chk("to_err_before", o_timeout_err, 0);
    i_err_clear = 1'b1;
    tick();
    i_err_clear = 1'b0;
    m_miso[1] = '0;
    m_dc[1]++;
    chk("to_done", o_req1_done, 1);
    chk("to_miso", o_req1_miso, 0);
    chk("to_err_set", o_timeout_err, 1);
    chk("to_busy", o_req1_busy, 0);
    repeat (5) tick();
    chk("to_err_sticky", o_timeout_err, 1);
    i_err_clear = 1'b1;
    tick();
    i_err_clear = 1'b0;
    chk("to_err_clear", o_timeout_err, 0);
    settle();

    // Stray completion while idle.
    i_spi_done = 1'b1;
    i_spi_miso = 24'hDEAD01;
    tick();
    chk("stray_done0", o_req0_done, 0);
    chk("stray_done1", o_req1_done, 0);
    tick();
    i_spi_done = 1'b0;
    tick();
    settle();

    // Reset in the middle of a transfer.
    model_request(1, 24'h0BEEF0, 2'd1);
    s = cyc;
    tick();
    clear_starts();
    wait_launch(s + 2);
    repeat (3) tick();
    i_rst = 1'b0;
    #1;
    chk_all_zero();
    tick();
    tick();
    i_rst = 1'b1;
    model_reset();
    tick();
    settle();
    run_batch(3, 24'h0A0A0A, 2'd0, 24'h1B1B1B, 24'h2C2C2C, 2'd1, 24'h3D3D3D, 1'b0);

    for (int k = 0; k < 15; k++) begin
      run_batch($urandom_range(1, 3),
                DW'($urandom), 2'($urandom), DW'($urandom),
                DW'($urandom), 2'($urandom), DW'($urandom),
                1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
